// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, the canonical NOP and the
// fetch-to-decode entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } if_id_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode bus. Handshake: a transfer happens on a rising edge where
// valid && ready; ready never depends combinationally on the opposite side's valid/ready.
interface if_id_queue_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_misaligned;

  // master: the pipeline around the queue (fetch drives in_*, decode drives out_ready)
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_misaligned
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_misaligned
  );

endinterface

// File: rtl/if_id_queue.sv
// In-order fetch-to-decode instruction queue with redirect flush. Outputs are
// driven purely from registered state, so there is no input-to-output bypass.
module if_id_queue #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  if_id_queue_if.slave               bus,
  output logic [$clog2(DEPTH):0]     count_o
);

  import riscv_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if_id_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  if_id_t             w_head_entry;

  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid  && w_in_ready  && !flush_i;
  assign w_pop       = w_out_valid   && bus.out_ready && !flush_i;

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= '{pc: bus.in_pc, inst: bus.in_inst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_entry = r_mem[r_head];

  always_comb begin
    bus.in_ready       = w_in_ready;
    bus.out_valid      = w_out_valid;
    bus.out_pc         = '0;
    bus.out_inst       = NOP_INST;
    bus.out_misaligned = 1'b0;
    if (w_out_valid) begin
      bus.out_pc         = w_head_entry.pc;
      bus.out_inst       = w_head_entry.inst;
      bus.out_misaligned = (w_head_entry.pc[1:0] != 2'b00);
    end
  end

  assign count_o = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, stall hold, full/back-pressure,
// streaming with wrap, flush, misalignment and asynchronous reset.
module tb_if_id_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic       flush_i;
  logic [1:0] count_o;

  int n_tests;
  int n_fail;

  if_id_queue_if #(.XLEN(XLEN)) bus ();

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus.slave),
    .count_o (count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    tick();
  endtask

  task automatic drain();
    @(negedge clk);
    drive_idle();
    bus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_tests++; if (bus.out_inst !== NOP) begin n_fail++; $display("FAIL reset_out_inst got %h exp %h", bus.out_inst, NOP); end
    n_tests++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
    n_tests++; if (bus.out_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got %0b exp 0", bus.out_misaligned); end
  endtask

  task automatic test_single_push_stall();
    drive_push(32'h100, 32'h0050_0093, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %0b exp 1", bus.out_valid); end
    n_tests++; if (bus.out_pc !== 32'h100) begin n_fail++; $display("FAIL single_out_pc got %h exp 100", bus.out_pc); end
    n_tests++; if (bus.out_inst !== 32'h0050_0093) begin n_fail++; $display("FAIL single_out_inst got %h exp 00500093", bus.out_inst); end
    n_tests++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count_o); end
    n_tests++; if (bus.out_misaligned !== 1'b0) begin n_fail++; $display("FAIL single_misaligned got %0b exp 0", bus.out_misaligned); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.out_pc !== 32'h100 || bus.out_inst !== 32'h0050_0093 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got pc=%h inst=%h v=%0b exp pc=100 inst=00500093 v=1", i, bus.out_pc, bus.out_inst, bus.out_valid);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    tick();
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL single_pop_count got %0d exp 0", count_o); end
    n_tests++; if (bus.out_inst !== NOP) begin n_fail++; $display("FAIL empty_out_inst got %h exp %h", bus.out_inst, NOP); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full();
    drive_push(32'h100, 32'hA000_0001, 1'b0);
    drive_push(32'h104, 32'hA000_0002, 1'b0);
    n_tests++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d exp 2", count_o); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %0b exp 0", bus.in_ready); end
    n_tests++; if (bus.out_pc !== 32'h100) begin n_fail++; $display("FAIL full_head_pc got %h exp 100", bus.out_pc); end
    // Fetch holds 0x108 while full; pop happens, push must not.
    drive_push(32'h108, 32'hA000_0003, 1'b1);
    n_tests++; if (bus.out_pc !== 32'h104) begin n_fail++; $display("FAIL full_pop_pc got %h exp 104", bus.out_pc); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_in_ready got %0b exp 1", bus.in_ready); end
    n_tests++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL full_pop_count got %0d exp 1", count_o); end
    drive_push(32'h108, 32'hA000_0003, 1'b1);
    n_tests++; if (bus.out_pc !== 32'h108 || bus.out_inst !== 32'hA000_0003) begin n_fail++; $display("FAIL full_held_entry got pc=%h inst=%h exp pc=108 inst=a0000003", bus.out_pc, bus.out_inst); end
    n_tests++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL full_swap_count got %0d exp 1", count_o); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive_push(32'(i * 4), 32'h0000_0013 | 32'(i << 7), 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) || bus.out_inst !== (32'h0000_0013 | 32'(i << 7)) || count_o !== 2'd1) begin
        n_fail++;
        $display("FAIL stream[%0d] got v=%0b pc=%h inst=%h cnt=%0d exp v=1 pc=%h inst=%h cnt=1",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, count_o, 32'(i * 4), 32'h0000_0013 | 32'(i << 7));
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tick();
    n_tests++; if (count_o !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got cnt=%0d v=%0b exp cnt=0 v=0", count_o, bus.out_valid); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive_push(32'h200, 32'hB000_0001, 1'b0);
    drive_push(32'h204, 32'hB000_0002, 1'b0);
    @(negedge clk);
    flush_i       = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h208;
    bus.in_inst   = 32'hB000_0003;
    bus.out_ready = 1'b1;
    tick();
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count_o); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b exp 0", bus.out_valid); end
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.out_pc === 32'h208) begin
        n_fail++;
        $display("FAIL flush_dropped[%0d] got v=%0b pc=%h exp v=0 pc=0", i, bus.out_valid, bus.out_pc);
      end
    end
    // After a flush the queue must restart cleanly in order.
    drive_push(32'h20C, 32'hB000_0004, 1'b0);
    drive_push(32'h210, 32'hB000_0005, 1'b1);
    n_tests++; if (bus.out_pc !== 32'h210 || count_o !== 2'd1) begin n_fail++; $display("FAIL flush_restart got pc=%h cnt=%0d exp pc=210 cnt=1", bus.out_pc, count_o); end
    drain();
  endtask

  task automatic test_misaligned();
    drive_push(32'h302, 32'hC000_0001, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_misaligned !== 1'b1) begin n_fail++; $display("FAIL misaligned_flag got %0b exp 1", bus.out_misaligned); end
    n_tests++; if (bus.out_pc !== 32'h302) begin n_fail++; $display("FAIL misaligned_pc got %h exp 302", bus.out_pc); end
    drain();
  endtask

  task automatic test_async_reset();
    drive_push(32'h400, 32'hD000_0001, 1'b0);
    drive_push(32'h404, 32'hD000_0002, 1'b0);
    n_tests++; if (count_o !== 2'd2) begin n_fail++; $display("FAIL areset_pre_count got %0d exp 2", count_o); end
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid got %0b exp 0", bus.out_valid); end
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL areset_count got %0d exp 0", count_o); end
    n_tests++; if (bus.out_inst !== NOP || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL areset_outputs got pc=%h inst=%h exp pc=0 inst=%h", bus.out_pc, bus.out_inst, NOP); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got %0b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    drive_idle();
    test_reset();
    test_single_push_stall();
    test_full();
    test_back_to_back();
    test_flush();
    test_misaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
